i2c_write_master: RTL



---
 rtl/hdmi_tx_pkg.sv | 68 ++++++
 rtl/i2c_quarter_tick.sv | 44 ++++
 rtl/i2c_write_master.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/hdmi_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module : hdmi_tx_pkg
// Purpose: Shared types and constants for the HDMI transmitter configuration
//          path. It holds the I2C write-master state encoding, the quarter
//          index type, the ADV7513 bus address, the ACK/NACK levels and the
//          function that maps a bus position to the open-drain pin drive.
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
package hdmi_tx_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      BYTE  = 3'd2,
      ACK   = 3'd3,
      STOP  = 3'd4,
      DONE  = 3'd5
   } i2c_state_t;

   typedef logic [1:0] quarter_t;

   localparam logic [6:0] ADV7513_ADDR = 7'h39;
   localparam logic       I2C_ACK      = 1'b0;
   localparam logic       I2C_NACK     = 1'b1;

   // Open-drain drive: a 1 pulls the line low, a 0 releases it.
   typedef struct packed {
      logic scl_low;
      logic sda_low;
   } bus_drv_t;

   // Pin drive for a given state/quarter. bit_val is the data bit sent in
   // BYTE; it is ignored everywhere else.
   function automatic bus_drv_t bus_drive(input i2c_state_t st,
                                          input quarter_t   q,
                                          input logic       bit_val);
      bus_drv_t d;
      d.scl_low = 1'b0;
      d.sda_low = 1'b0;
      case (st)
         START: begin
            d.scl_low = (q == 2'd3);
            d.sda_low = q[1];
         end
         BYTE: begin
            d.scl_low = (q == 2'd0) || (q == 2'd3);
            d.sda_low = ~bit_val;
         end
         ACK: begin
            d.scl_low = (q == 2'd0) || (q == 2'd3);
            d.sda_low = 1'b0;
         end
         STOP: begin
            d.scl_low = (q == 2'd0);
            d.sda_low = ~q[1];
         end
         default: begin
            d.scl_low = 1'b0;
            d.sda_low = 1'b0;
         end
      endcase
      return d;
   endfunction

endpackage : hdmi_tx_pkg
`default_nettype wire

// File: rtl/i2c_quarter_tick.sv
`default_nettype none
// ============================================================================
// Module : i2c_quarter_tick
// Purpose: Quarter-SCL-period strobe generator. A counter runs
//          0..QUARTER_DIV-1 while enabled; tick is high on its last count.
//          hold forces the counter to 0 and suppresses tick (clock stretch).
// Ports  : clock_25 - system clock
//          reset    - asynchronous active-low reset
//          enable   - count while high, clear to 0 while low
//          hold     - keep the counter at 0
//          tick     - one-cycle strobe at the end of each quarter
// Rev    : 1.0  initial release
// ============================================================================
module i2c_quarter_tick #(
   parameter int QUARTER_DIV = 62,
   parameter int CNT_W       = 8
) (
   input  logic clock_25,
   input  logic reset,
   input  logic enable,
   input  logic hold,
   output logic tick
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(QUARTER_DIV - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clock_25 or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (!enable || hold) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tick = enable & ~hold & (cnt == LAST);

endmodule : i2c_quarter_tick
`default_nettype wire

// File: rtl/i2c_write_master.sv
`default_nettype none
// ============================================================================
// Module : i2c_write_master
// Purpose: Byte-level I2C master for single-register writes on the ADV7513
//          configuration bus: START, {dev_addr,W}, reg_addr, wr_data, STOP.
//          Each bit is four quarters of QUARTER_DIV clocks; SDA moves only
//          at the start of q0 (SCL low) and is sampled on the last cycle of q1.
// Config : define I2C_CLOCK_STRETCH_EN to let a slave stretch SCL; q1 then
//          waits for SCL to read high. Without it SCL is never read back.
// Ports  : clock_25         - 25 MHz system clock
//          reset            - asynchronous active-low reset
//          start            - write request, sampled only in IDLE
//          dev_addr         - 7-bit slave address
//          reg_addr         - register address
//          wr_data          - register value
//          busy             - transaction in progress
//          done             - one-cycle pulse at transaction end
//          ack_error        - a NACK was received; held until next start
//          i2c_serial_data  - SDA, open drain (0 or z)
//          i2c_serial_clock - SCL, open drain (0 or z)
// Rev    : 1.0  initial release
// ============================================================================
module i2c_write_master
   import hdmi_tx_pkg::*;
#(
   parameter int QUARTER_DIV = 62,
   parameter int CNT_W       = 8
) (
   input  logic       clock_25,
   input  logic       reset,
   input  logic       start,
   input  logic [6:0] dev_addr,
   input  logic [7:0] reg_addr,
   input  logic [7:0] wr_data,
   output logic       busy,
   output logic       done,
   output logic       ack_error,
   inout  wire        i2c_serial_data,
   inout  wire        i2c_serial_clock
);

   i2c_state_t state;
   quarter_t   quarter;
   quarter_t   q_next;
   logic [2:0] bit_cnt;
   logic [1:0] byte_cnt;
   logic [7:0] shift;
   logic [7:0] reg_lat;
   logic [7:0] data_lat;
   logic [7:0] next_byte;
   logic       ack_bit;
   logic       scl_low;
   logic       sda_low;
   logic       tick;
   logic       tick_en;
   logic       hold;

   assign i2c_serial_data  = sda_low ? 1'b0 : 1'bz;
   assign i2c_serial_clock = scl_low ? 1'b0 : 1'bz;

   assign q_next    = quarter + 2'd1;
   assign tick_en   = (state != IDLE) && (state != DONE);
   // Byte loaded after the ACK of byte byte_cnt.
   assign next_byte = (byte_cnt == 2'd0) ? reg_lat : data_lat;

`ifdef I2C_CLOCK_STRETCH_EN
   // A slave holding SCL low during q1 freezes the quarter counter at 0;
   // q1 only starts counting once SCL is actually seen high.
   assign hold = tick_en && (quarter == 2'd1) && (i2c_serial_clock == 1'b0);
`else
   wire unused_scl = i2c_serial_clock;
   assign hold = 1'b0;
`endif

   i2c_quarter_tick #(
      .QUARTER_DIV (QUARTER_DIV),
      .CNT_W       (CNT_W)
   ) u_quarter_tick (
      .clock_25 (clock_25),
      .reset    (reset),
      .enable   (tick_en),
      .hold     (hold),
      .tick     (tick)
   );

   // Pin drive registers are loaded with the pattern of the quarter being
   // entered, so the lines change exactly at quarter boundaries.
   always_ff @(posedge clock_25 or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         quarter   <= 2'd0;
         bit_cnt   <= 3'd0;
         byte_cnt  <= 2'd0;
         shift     <= 8'h00;
         reg_lat   <= 8'h00;
         data_lat  <= 8'h00;
         ack_bit   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         ack_error <= 1'b0;
         scl_low   <= 1'b0;
         sda_low   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  shift     <= {dev_addr, 1'b0};
                  reg_lat   <= reg_addr;
                  data_lat  <= wr_data;
                  ack_error <= 1'b0;
                  busy      <= 1'b1;
                  quarter   <= 2'd0;
                  bit_cnt   <= 3'd0;
                  byte_cnt  <= 2'd0;
                  state     <= START;
               end
            end

            START: begin
               if (tick) begin
                  quarter <= q_next;
                  if (quarter == 2'd3) begin
                     state              <= BYTE;
                     {scl_low, sda_low} <= bus_drive(BYTE, 2'd0, shift[7]);
                  end else begin
                     {scl_low, sda_low} <= bus_drive(START, q_next, 1'b1);
                  end
               end
            end

            BYTE: begin
               if (tick) begin
                  quarter <= q_next;
                  if (quarter == 2'd3) begin
                     shift <= {shift[6:0], 1'b0};
                     if (bit_cnt == 3'd7) begin
                        bit_cnt            <= 3'd0;
                        state              <= ACK;
                        {scl_low, sda_low} <= bus_drive(ACK, 2'd0, 1'b1);
                     end else begin
                        bit_cnt            <= bit_cnt + 3'd1;
                        {scl_low, sda_low} <= bus_drive(BYTE, 2'd0, shift[6]);
                     end
                  end else begin
                     {scl_low, sda_low} <= bus_drive(BYTE, q_next, shift[7]);
                  end
               end
            end

            ACK: begin
               if (tick) begin
                  quarter <= q_next;
                  if (quarter == 2'd1) begin
                     ack_bit <= i2c_serial_data;
                  end
                  if (quarter == 2'd3) begin
                     if (ack_bit != I2C_ACK) begin
                        ack_error          <= 1'b1;
                        state              <= STOP;
                        {scl_low, sda_low} <= bus_drive(STOP, 2'd0, 1'b1);
                     end else if (byte_cnt == 2'd2) begin
                        state              <= STOP;
                        {scl_low, sda_low} <= bus_drive(STOP, 2'd0, 1'b1);
                     end else begin
                        byte_cnt           <= byte_cnt + 2'd1;
                        shift              <= next_byte;
                        state              <= BYTE;
                        {scl_low, sda_low} <= bus_drive(BYTE, 2'd0, next_byte[7]);
                     end
                  end else begin
                     {scl_low, sda_low} <= bus_drive(ACK, q_next, 1'b1);
                  end
               end
            end

            STOP: begin
               if (tick) begin
                  quarter <= q_next;
                  if (quarter == 2'd3) begin
                     state              <= DONE;
                     done               <= 1'b1;
                     {scl_low, sda_low} <= bus_drive(IDLE, 2'd0, 1'b1);
                  end else begin
                     {scl_low, sda_low} <= bus_drive(STOP, q_next, 1'b1);
                  end
               end
            end

            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end

            default: begin
               busy               <= 1'b0;
               state              <= IDLE;
               {scl_low, sda_low} <= 2'b00;
            end
         endcase
      end
   end

endmodule : i2c_write_master
`default_nettype wire
